// File: rtl/eth_length_pkg.sv
// Ethernet length-path definitions shared by the RX length FIFO and the TX length framer.
package eth_length_pkg;

    localparam int ETH_MIN_PACKET_LENGTH = 64;
    localparam int ETH_MAX_PACKET_LENGTH = 1522;
    localparam int LENGTH_WIDTH          = $clog2(ETH_MAX_PACKET_LENGTH);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } len_state_e;

endpackage

// File: rtl/axis_length_framer.sv
// Slices an unframed byte stream into AXI-Stream frames whose sizes come from a length stream.
// Oversize lengths are clipped to MAX_LEN and the clipped frame is marked bad on its tlast beat.
module axis_length_framer
    import eth_length_pkg::*;
#(
    parameter int LEN_WIDTH = LENGTH_WIDTH,
    parameter int MAX_LEN   = ETH_MAX_PACKET_LENGTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_WIDTH-1:0] s_len_tdata,
    input  logic                 s_len_tvalid,
    output logic                 s_len_tready,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 status_zero_len,
    output logic                 status_truncated
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN_W = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] ONE       = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] ZERO      = '0;

    len_state_e           state_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic                 bad_q;
    logic [7:0]           tdata_q;
    logic                 tvalid_q;
    logic                 tlast_q;
    logic                 tuser_q;
    logic                 zero_q;
    logic                 trunc_q;

    logic out_free;
    logic in_fire;
    logic last_beat;
    logic len_fire;

    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        return (len > MAX_LEN_W) ? MAX_LEN_W : len;
    endfunction

    // The length port also opens on the closing beat of a frame so the next
    // descriptor loads in the same cycle and frames run without a bubble.
    always_comb begin
        out_free      = !tvalid_q || m_axis_tready;
        s_axis_tready = !rst && (state_q == DATA) && out_free;
        in_fire       = s_axis_tvalid && s_axis_tready;
        last_beat     = in_fire && (remaining_q == ONE);
        s_len_tready  = !rst && ((state_q == IDLE) || last_beat);
        len_fire      = s_len_tvalid && s_len_tready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= ZERO;
            bad_q       <= 1'b0;
            tdata_q     <= 8'h00;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            zero_q      <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            zero_q  <= 1'b0;
            trunc_q <= 1'b0;

            if (tvalid_q && m_axis_tready) begin
                tvalid_q <= 1'b0;
            end

            if (in_fire) begin
                tdata_q     <= s_axis_tdata;
                tvalid_q    <= 1'b1;
                tlast_q     <= (remaining_q == ONE);
                tuser_q     <= (remaining_q == ONE) && bad_q;
                remaining_q <= remaining_q - ONE;
                if (remaining_q == ONE) begin
                    bad_q   <= 1'b0;
                    state_q <= IDLE;
                end
            end

            // A descriptor taken on a closing beat overrides the return to IDLE.
            if (len_fire) begin
                if (s_len_tdata == ZERO) begin
                    zero_q <= 1'b1;
                end else begin
                    remaining_q <= clamp_len(s_len_tdata);
                    bad_q       <= (s_len_tdata > MAX_LEN_W);
                    trunc_q     <= (s_len_tdata > MAX_LEN_W);
                    state_q     <= DATA;
                end
            end
        end
    end

    assign m_axis_tdata     = tdata_q;
    assign m_axis_tvalid    = tvalid_q;
    assign m_axis_tlast     = tlast_q;
    assign m_axis_tuser     = tuser_q;
    assign status_zero_len  = zero_q;
    assign status_truncated = trunc_q;

endmodule
